seq_divider: RTL and testbench

Multi-cycle restoring divider implementing 8086 DIV/IDIV semantics for 8-bit (AX ÷ r/m8) and 16-bit (DX:AX ÷ r/m16) operands. It sits beside the combinational ALU in the execute stage. The microcode sequencer starts it and stalls on `busy`, then collects quotient, remainder and divide-error status. Divide error drives the INT 0 microcode path.

---
 rtl/seq_divider.sv | 238 +++++++++++++++++++++++
 tb/tb_seq_divider.sv | 200 ++++++++++++++++++++
 2 files changed

// File: rtl/seq_divider.sv
// Multi-cycle restoring divider with 8086 DIV/IDIV semantics (8-bit and 16-bit forms).
// Define SEQ_DIVIDER_SIGNED_EN to build in IDIV support; otherwise every operation is unsigned.
module seq_divider (
  input  logic        clk,
  input  logic        reset_n,
  input  logic        start,
  input  logic        is_8_bit,
  input  logic        is_signed,
  input  logic [31:0] dividend,
  input  logic [15:0] divisor,
  output logic        busy,
  output logic        complete,
  output logic        error,
  output logic [15:0] quotient,
  output logic [15:0] remainder
);

  typedef enum logic [2:0] {
    ST_IDLE = 3'd0,
    ST_PREP = 3'd1,
    ST_DIV  = 3'd2,
    ST_FIX  = 3'd3,
    ST_DONE = 3'd4
  } state_t;

  state_t      state_r, state_nxt_s;
  logic [31:0] dvd_r;
  logic [15:0] dvs_r;
  logic        mode8_r;
  logic [15:0] dvs_mag_r;
  logic [15:0] rem_r;
  logic [15:0] quo_r;
  logic [4:0]  count_r;
  logic        busy_r, complete_r, error_r;
  logic [15:0] quotient_r, remainder_r;

  logic [31:0] dvd_mag_s;
  logic [15:0] dvs_mag_s;
  logic [15:0] hi_s, lo_s;
  logic        prep_err_s;
  logic [16:0] trial_s;
  logic        qbit_s;
  logic [15:0] rem_nxt_s;
  logic        range_err_s;
  logic [15:0] q_fix_s, r_fix_s;

`ifdef SEQ_DIVIDER_SIGNED_EN
  logic signed_r;
  logic dvd_neg_s, dvs_neg_s;

  function automatic logic [7:0] neg8(input logic [7:0] v);
    return ~v + 8'd1;
  endfunction

  function automatic logic [15:0] neg16(input logic [15:0] v);
    return ~v + 16'd1;
  endfunction

  function automatic logic [31:0] neg32(input logic [31:0] v);
    return ~v + 32'd1;
  endfunction

  // Operation mode flag latched alongside the operands
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      signed_r <= 1'b0;
    end else if (state_r == ST_IDLE && start) begin
      signed_r <= is_signed;
    end else begin
      signed_r <= signed_r;
    end
  end

  assign dvd_neg_s = signed_r & (mode8_r ? dvd_r[15] : dvd_r[31]);
  assign dvs_neg_s = signed_r & (mode8_r ? dvs_r[7]  : dvs_r[15]);
`else
  logic unused_is_signed_s;
  assign unused_is_signed_s = is_signed;
`endif

  // Operand magnitudes and the early divide-error check used in PREP
  always_comb begin
    dvd_mag_s = 32'h0000_0000;
    dvs_mag_s = 16'h0000;
`ifdef SEQ_DIVIDER_SIGNED_EN
    if (mode8_r) begin
      dvd_mag_s = {16'h0000, (dvd_neg_s ? neg16(dvd_r[15:0]) : dvd_r[15:0])};
      dvs_mag_s = {8'h00, (dvs_neg_s ? neg8(dvs_r[7:0]) : dvs_r[7:0])};
    end else begin
      dvd_mag_s = dvd_neg_s ? neg32(dvd_r) : dvd_r;
      dvs_mag_s = dvs_neg_s ? neg16(dvs_r) : dvs_r;
    end
`else
    if (mode8_r) begin
      dvd_mag_s = {16'h0000, dvd_r[15:0]};
      dvs_mag_s = {8'h00, dvs_r[7:0]};
    end else begin
      dvd_mag_s = dvd_r;
      dvs_mag_s = dvs_r;
    end
`endif
  end

  // 8-bit operands are left-aligned so the shift always pulls from quo_r[15]
  assign hi_s       = mode8_r ? {8'h00, dvd_mag_s[15:8]} : dvd_mag_s[31:16];
  assign lo_s       = mode8_r ? {dvd_mag_s[7:0], 8'h00}  : dvd_mag_s[15:0];
  assign prep_err_s = (dvs_mag_s == 16'h0000) || (hi_s >= dvs_mag_s);

  assign trial_s   = {rem_r, quo_r[15]};
  assign qbit_s    = (trial_s >= {1'b0, dvs_mag_r});
  assign rem_nxt_s = qbit_s ? (trial_s[15:0] - dvs_mag_r) : trial_s[15:0];

  // Sign application and IDIV range check applied in FIX
  always_comb begin
    range_err_s = 1'b0;
    q_fix_s     = mode8_r ? {8'h00, quo_r[7:0]} : quo_r;
    r_fix_s     = mode8_r ? {8'h00, rem_r[7:0]} : rem_r;
`ifdef SEQ_DIVIDER_SIGNED_EN
    if (signed_r) begin
      range_err_s = mode8_r ? (quo_r[7:0] > 8'h7F) : (quo_r > 16'h7FFF);
    end else begin
      range_err_s = 1'b0;
    end
    if (dvd_neg_s ^ dvs_neg_s) begin
      q_fix_s = mode8_r ? {8'h00, neg8(quo_r[7:0])} : neg16(quo_r);
    end else begin
      q_fix_s = mode8_r ? {8'h00, quo_r[7:0]} : quo_r;
    end
    if (dvd_neg_s) begin
      r_fix_s = mode8_r ? {8'h00, neg8(rem_r[7:0])} : neg16(rem_r);
    end else begin
      r_fix_s = mode8_r ? {8'h00, rem_r[7:0]} : rem_r;
    end
`endif
  end

  // State register
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_r <= ST_IDLE;
    end else begin
      state_r <= state_nxt_s;
    end
  end

  // Next-state logic
  always_comb begin
    state_nxt_s = state_r;
    case (state_r)
      ST_IDLE: begin
        if (start) state_nxt_s = ST_PREP;
        else       state_nxt_s = ST_IDLE;
      end
      ST_PREP: begin
        if (prep_err_s) state_nxt_s = ST_DONE;
        else            state_nxt_s = ST_DIV;
      end
      ST_DIV: begin
        if (count_r == 5'd1) state_nxt_s = ST_FIX;
        else                 state_nxt_s = ST_DIV;
      end
      ST_FIX:  state_nxt_s = ST_DONE;
      ST_DONE: state_nxt_s = ST_IDLE;
      default: state_nxt_s = ST_IDLE;
    endcase
  end

  // Datapath and registered outputs
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      dvd_r       <= 32'h0000_0000;
      dvs_r       <= 16'h0000;
      mode8_r     <= 1'b0;
      dvs_mag_r   <= 16'h0000;
      rem_r       <= 16'h0000;
      quo_r       <= 16'h0000;
      count_r     <= 5'd0;
      busy_r      <= 1'b0;
      complete_r  <= 1'b0;
      error_r     <= 1'b0;
      quotient_r  <= 16'h0000;
      remainder_r <= 16'h0000;
    end else begin
      complete_r <= 1'b0;
      case (state_r)
        ST_IDLE: begin
          if (start) begin
            dvd_r       <= dividend;
            dvs_r       <= divisor;
            mode8_r     <= is_8_bit;
            busy_r      <= 1'b1;
            error_r     <= 1'b0;
            quotient_r  <= 16'h0000;
            remainder_r <= 16'h0000;
          end
        end
        ST_PREP: begin
          if (prep_err_s) begin
            error_r    <= 1'b1;
            complete_r <= 1'b1;
          end else begin
            rem_r     <= hi_s;
            quo_r     <= lo_s;
            dvs_mag_r <= dvs_mag_s;
            count_r   <= mode8_r ? 5'd8 : 5'd16;
          end
        end
        ST_DIV: begin
          rem_r   <= rem_nxt_s;
          quo_r   <= {quo_r[14:0], qbit_s};
          count_r <= count_r - 5'd1;
        end
        ST_FIX: begin
          complete_r <= 1'b1;
          if (range_err_s) begin
            error_r <= 1'b1;
          end else begin
            quotient_r  <= q_fix_s;
            remainder_r <= r_fix_s;
          end
        end
        ST_DONE: begin
          busy_r <= 1'b0;
        end
        default: begin
          busy_r <= 1'b0;
        end
      endcase
    end
  end

  assign busy      = busy_r;
  assign complete  = complete_r;
  assign error     = error_r;
  assign quotient  = quotient_r;
  assign remainder = remainder_r;

endmodule

// File: tb/tb_seq_divider.sv
// Self-checking bench for seq_divider: spec vectors, reset abort, and random ops vs an arithmetic model.
module tb_seq_divider;

  logic        clk = 1'b0;
  logic        reset_n, start, is_8_bit, is_signed;
  logic [31:0] dividend;
  logic [15:0] divisor;
  logic        busy, complete, error;
  logic [15:0] quotient, remainder;

  int n_chk  = 0;
  int n_fail = 0;
  logic [15:0] last_q, last_r;
  logic        last_err;

  typedef struct {
    string       name;
    bit          is8;
    bit          sgn;
    logic [31:0] dvd;
    logic [15:0] dvs;
    logic        e_err;
    logic [15:0] e_q;
    logic [15:0] e_r;
    int          e_lat;
  } vec_t;

  vec_t vecs[8];

  always #5 clk = ~clk;

  seq_divider dut (
    .clk(clk), .reset_n(reset_n), .start(start), .is_8_bit(is_8_bit),
    .is_signed(is_signed), .dividend(dividend), .divisor(divisor),
    .busy(busy), .complete(complete), .error(error),
    .quotient(quotient), .remainder(remainder)
  );

  task automatic chk(input string name, input longint act, input longint exp);
    n_chk++;
    if (act != exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
    end
  endtask

  // Truncating integer division as the 8086 defines it
  function automatic void ref_div(input bit is8, input bit sgn_in, input logic [31:0] dvd,
                                  input logic [15:0] dvs, output logic err,
                                  output logic [15:0] q, output logic [15:0] r, output int lat);
    longint a, b, ma, mb, qm, rm, qs, rs, one, n;
    bit sgn;
`ifdef SEQ_DIVIDER_SIGNED_EN
    sgn = sgn_in;
`else
    sgn = 1'b0;
    if (sgn_in) sgn = 1'b0;
`endif
    one = 1;
    n = is8 ? 8 : 16;
    if (is8) begin
      a = dvd[15:0]; b = dvs[7:0];
      if (sgn && a >= 32768) a = a - 65536;
      if (sgn && b >= 128)   b = b - 256;
    end else begin
      a = dvd; b = dvs;
      if (sgn && dvd[31]) a = a - (one << 32);
      if (sgn && dvs[15]) b = b - 65536;
    end
    err = 1'b0; q = 16'h0; r = 16'h0;
    if (b == 0) begin err = 1'b1; lat = 2; return; end
    ma = (a < 0) ? -a : a;
    mb = (b < 0) ? -b : b;
    qm = ma / mb;
    rm = ma % mb;
    if (qm >= (one << n)) begin err = 1'b1; lat = 2; return; end
    lat = int'(n) + 3;
    if (sgn && qm > ((one << (n - 1)) - 1)) begin err = 1'b1; return; end
    qs = ((a < 0) != (b < 0)) ? -qm : qm;
    rs = (a < 0) ? -rm : rm;
    q = 16'(qs & ((one << n) - 1));
    r = 16'(rs & ((one << n) - 1));
  endfunction

  task automatic do_op(input string name, input bit is8, input bit sgn, input logic [31:0] dvd,
                       input logic [15:0] dvs, input logic e_err, input logic [15:0] e_q,
                       input logic [15:0] e_r, input int e_lat);
    int lat = 0;
    bit busy_ok = 1'b1;
    @(negedge clk);
    chk({name, " idle busy"}, busy, 0);
    chk({name, " idle complete"}, complete, 0);
    chk({name, " held quotient"}, quotient, last_q);
    chk({name, " held error"}, error, last_err);
    start = 1'b1; is_8_bit = is8; is_signed = sgn; dividend = dvd; divisor = dvs;
    @(posedge clk);
    #1;
    start = 1'b0;
    dividend = $urandom; divisor = 16'($urandom);
    is_8_bit = 1'($urandom); is_signed = 1'($urandom);
    for (int k = 1; k <= 30; k++) begin
      @(negedge clk);
      if (complete) begin
        lat = k;
        break;
      end
      if (!busy) busy_ok = 1'b0;
    end
    chk({name, " latency"}, lat, e_lat);
    chk({name, " busy before complete"}, busy_ok, 1);
    chk({name, " busy at complete"}, busy, 1);
    chk({name, " error"}, error, e_err);
    chk({name, " quotient"}, quotient, e_q);
    chk({name, " remainder"}, remainder, e_r);
    last_q = e_q; last_r = e_r; last_err = e_err;
  endtask

  initial begin
    logic        m_err;
    logic [15:0] m_q, m_r;
    int          m_lat;
    bit          r8, rs;
    logic [31:0] rdvd;
    logic [15:0] rdvs;

    vecs[0] = '{"u16 10000/3", 1'b0, 1'b0, 32'h0001_0000, 16'h0003, 1'b0, 16'h5555, 16'h0001, 19};
    vecs[1] = '{"u8 64/7",     1'b1, 1'b0, 32'h0000_0064, 16'h0007, 1'b0, 16'h000E, 16'h0002, 11};
    vecs[2] = '{"div0",        1'b0, 1'b0, 32'h0000_1234, 16'h0000, 1'b1, 16'h0000, 16'h0000, 2};
    vecs[3] = '{"u16 ovf",     1'b0, 1'b0, 32'h0001_0000, 16'h0001, 1'b1, 16'h0000, 16'h0000, 2};
    vecs[4] = '{"u16 max",     1'b0, 1'b0, 32'hFFFE_FFFF, 16'hFFFF, 1'b0, 16'hFFFF, 16'hFFFE, 19};
`ifdef SEQ_DIVIDER_SIGNED_EN
    vecs[5] = '{"s8 -7/2",     1'b1, 1'b1, 32'h0000_FFF9, 16'h0002, 1'b0, 16'h00FD, 16'h00FF, 11};
    vecs[6] = '{"s16 range",   1'b0, 1'b1, 32'hFFFF_8000, 16'hFFFF, 1'b1, 16'h0000, 16'h0000, 19};
    vecs[7] = '{"s8 128/-1",   1'b1, 1'b1, 32'h0000_0080, 16'h00FF, 1'b1, 16'h0000, 16'h0000, 11};
`else
    vecs[5] = '{"s8 -7/2",     1'b1, 1'b1, 32'h0000_FFF9, 16'h0002, 1'b1, 16'h0000, 16'h0000, 2};
    vecs[6] = '{"s16 range",   1'b0, 1'b1, 32'hFFFF_8000, 16'hFFFF, 1'b1, 16'h0000, 16'h0000, 2};
    vecs[7] = '{"s8 128/-1",   1'b1, 1'b1, 32'h0000_0080, 16'h00FF, 1'b0, 16'h0000, 16'h0080, 11};
`endif

    reset_n = 1'b0; start = 1'b0; is_8_bit = 1'b0; is_signed = 1'b0;
    dividend = 32'h0; divisor = 16'h0;
    last_q = 16'h0; last_r = 16'h0; last_err = 1'b0;
    repeat (2) @(negedge clk);
    chk("reset busy", busy, 0);
    chk("reset complete", complete, 0);
    chk("reset error", error, 0);
    chk("reset quotient", quotient, 0);
    chk("reset remainder", remainder, 0);
    reset_n = 1'b1;

    for (int i = 0; i < 8; i++)
      do_op(vecs[i].name, vecs[i].is8, vecs[i].sgn, vecs[i].dvd, vecs[i].dvs,
            vecs[i].e_err, vecs[i].e_q, vecs[i].e_r, vecs[i].e_lat);

    // Abort a 16-bit divide with reset at T+5
    @(negedge clk);
    start = 1'b1; is_8_bit = 1'b0; is_signed = 1'b0;
    dividend = 32'h0001_0000; divisor = 16'h0003;
    @(posedge clk);
    #1 start = 1'b0;
    repeat (5) @(negedge clk);
    chk("abort busy before reset", busy, 1);
    reset_n = 1'b0;
    #1;
    chk("abort busy", busy, 0);
    chk("abort complete", complete, 0);
    chk("abort error", error, 0);
    chk("abort quotient", quotient, 0);
    chk("abort remainder", remainder, 0);
    @(negedge clk);
    chk("abort no complete", complete, 0);
    reset_n = 1'b1;
    last_q = 16'h0; last_r = 16'h0; last_err = 1'b0;
    do_op("after reset 64/A", 1'b0, 1'b0, 32'h0000_0064, 16'h000A, 1'b0, 16'h000A, 16'h0000, 19);

    for (int i = 0; i < 40; i++) begin
      r8 = 1'($urandom);
      rs = 1'($urandom);
      case ($urandom_range(0, 3))
        0:       rdvd = $urandom;
        1:       rdvd = $urandom >> $urandom_range(8, 20);
        2:       rdvd = -($urandom >> $urandom_range(8, 20));
        default: rdvd = $urandom & 32'h0000_FFFF;
      endcase
      case ($urandom_range(0, 9))
        0:       rdvs = 16'h0000;
        1, 2, 3: rdvs = 16'($urandom_range(1, 300));
        4, 5:    rdvs = -16'($urandom_range(1, 300));
        default: rdvs = 16'($urandom);
      endcase
      ref_div(r8, rs, rdvd, rdvs, m_err, m_q, m_r, m_lat);
      do_op($sformatf("rand%0d", i), r8, rs, rdvd, rdvs, m_err, m_q, m_r, m_lat);
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule
